// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller.
//   - opcode / funct values of the supported instructions
//   - select codes for ALUctr, ExtOp, npc_sel, destination and write-data muxes
//   - 3-bit sequencer state enum and the instruction-class one-hot struct
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_PASS = 3'b011;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;

  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_RA   = 2'b10;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_DM    = 2'b01;
  localparam logic [1:0] WD_PC4   = 2'b10;
  localparam logic [1:0] WD_EXT   = 2'b11;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_DCD = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  // At most one bit set; all-zero means the encoding is unsupported.
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
  } iclass_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier.
//   i_op      [5:0]  instr[31:26]
//   i_funct   [5:0]  instr[5:0] (only meaningful for R-type)
//   o_cls            one-hot instruction class
//   o_illegal        high when no supported instruction matches
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output iclass_t    o_cls,
  output logic       o_illegal
);

  always_comb begin
    o_cls = '0;
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADDU: o_cls.addu = 1'b1;
          FN_SUBU: o_cls.subu = 1'b1;
          default: o_cls = '0;
        endcase
      end
      OP_ORI:  o_cls.ori = 1'b1;
      OP_LUI:  o_cls.lui = 1'b1;
      OP_LW:   o_cls.lw  = 1'b1;
      OP_SW:   o_cls.sw  = 1'b1;
      OP_BEQ:  o_cls.beq = 1'b1;
      OP_J:    o_cls.j   = 1'b1;
      OP_JAL:  o_cls.jal = 1'b1;
      default: o_cls = '0;
    endcase
    o_illegal = (o_cls == '0);
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencer for the MIPS datapath: walks each instruction
// through IF/DCD/EXE/MEM/WB and drives every datapath select and strobe.
//   clk, rst (async, active low)
//   op, funct   instruction fields from IR
//   beqout      ALU equality result, consumed in EXE of beq
//   ALUctr, ExtOp, npc_sel, mux4_5sel, mux4_32sel, mux2sel   datapath selects
//   PCWr, IRWr, RegWrt, DMWrite                              write strobes
//   instr_done  equals PCWr (one pulse per instruction)
//   illegal     pulse in DCD for unsupported op/funct (retired as a nop)
//   instret     retired-instruction count, wraps silently
//   o_dbg_state current sequencer state
module mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             beqout,
  output logic [2:0]       ALUctr,
  output logic [1:0]       ExtOp,
  output logic [1:0]       npc_sel,
  output logic [1:0]       mux4_5sel,
  output logic [1:0]       mux4_32sel,
  output logic             mux2sel,
  output logic             PCWr,
  output logic             IRWr,
  output logic             RegWrt,
  output logic             DMWrite,
  output logic             instr_done,
  output logic             illegal,
  output logic [RET_W-1:0] instret,
  output logic [2:0]       o_dbg_state
);

  state_t           r_state;
  logic [RET_W-1:0] r_instret;
  iclass_t          w_cls;
  logic             w_illegal;

  mc_ctrl_decode u_decode (
    .i_op      (op),
    .i_funct   (funct),
    .o_cls     (w_cls),
    .o_illegal (w_illegal)
  );

  // Outputs are decoded from the registered state rather than registered
  // themselves: IR loads on the IF->DCD edge, so the DCD decode can only see
  // the new op/funct combinationally. In S_IF every strobe except IRWr is 0,
  // which also makes reset safe (no partial RegFile/DM write).
  always_comb begin
    ALUctr     = ALU_ADD;
    ExtOp      = EXT_ZERO;
    npc_sel    = NPC_PC4;
    mux4_5sel  = DST_RT;
    mux4_32sel = WD_ALU;
    mux2sel    = 1'b0;
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    RegWrt     = 1'b0;
    DMWrite    = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_IF: IRWr = 1'b1;
      S_DCD: begin
        if (w_cls.j || w_cls.jal) begin
          PCWr    = 1'b1;
          npc_sel = NPC_JMP;
        end
        if (w_cls.jal) begin
          RegWrt     = 1'b1;
          mux4_5sel  = DST_RA;
          mux4_32sel = WD_PC4;
        end
        if (w_illegal) begin
          illegal = 1'b1;
          PCWr    = 1'b1;
        end
      end
      S_EXE, S_MEM, S_WB: begin
        // ALU/extender controls are held from EXE through MEM and WB so the
        // ALU result stays valid while DM or RegFile consumes it.
        if (w_cls.subu || w_cls.beq) ALUctr = ALU_SUB;
        if (w_cls.ori) begin
          ALUctr  = ALU_OR;
          mux2sel = 1'b1;
        end
        if (w_cls.lui) ExtOp = EXT_LUI;
        if (w_cls.lw || w_cls.sw) begin
          ExtOp   = EXT_SIGN;
          mux2sel = 1'b1;
        end
        if (w_cls.beq) ExtOp = EXT_SIGN;
        if (r_state == S_EXE && w_cls.beq) begin
          PCWr    = 1'b1;
          npc_sel = beqout ? NPC_BR : NPC_PC4;
        end
        if (r_state == S_MEM && w_cls.sw) begin
          DMWrite = 1'b1;
          PCWr    = 1'b1;
        end
        if (r_state == S_WB) begin
          RegWrt = 1'b1;
          PCWr   = 1'b1;
          if (w_cls.addu || w_cls.subu) mux4_5sel = DST_RD;
          if (w_cls.lui) mux4_32sel = WD_EXT;
          if (w_cls.lw)  mux4_32sel = WD_DM;
        end
      end
      default: IRWr = 1'b0;
    endcase
    instr_done = PCWr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IF;
      r_instret <= '0;
    end else begin
      if (PCWr) r_instret <= r_instret + {{(RET_W-1){1'b0}}, 1'b1};
      case (r_state)
        S_IF:    r_state <= S_DCD;
        S_DCD:   r_state <= (w_cls.j || w_cls.jal || w_illegal) ? S_IF : S_EXE;
        S_EXE: begin
          if (w_cls.beq)                r_state <= S_IF;
          else if (w_cls.lw || w_cls.sw) r_state <= S_MEM;
          else                          r_state <= S_WB;
        end
        S_MEM:   r_state <= w_cls.sw ? S_IF : S_WB;
        S_WB:    r_state <= S_IF;
        default: r_state <= S_IF;
      endcase
    end
  end

  assign instret     = r_instret;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

  localparam int RET_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [5:0]       op = '0;
  logic [5:0]       funct = '0;
  logic             beqout = 1'b0;
  logic [2:0]       ALUctr;
  logic [1:0]       ExtOp, npc_sel, mux4_5sel, mux4_32sel;
  logic             mux2sel, PCWr, IRWr, RegWrt, DMWrite, instr_done, illegal;
  logic [RET_W-1:0] instret;
  logic [2:0]       o_dbg_state;

  mc_ctrl #(.RET_W(RET_W)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .beqout(beqout),
    .ALUctr(ALUctr), .ExtOp(ExtOp), .npc_sel(npc_sel), .mux4_5sel(mux4_5sel),
    .mux4_32sel(mux4_32sel), .mux2sel(mux2sel), .PCWr(PCWr), .IRWr(IRWr),
    .RegWrt(RegWrt), .DMWrite(DMWrite), .instr_done(instr_done),
    .illegal(illegal), .instret(instret), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Packed view of all single-instruction outputs.
  logic [17:0] w_out;
  assign w_out = {ALUctr, ExtOp, npc_sel, mux4_5sel, mux4_32sel, mux2sel,
                  PCWr, IRWr, RegWrt, DMWrite, instr_done, illegal};

  function automatic logic [17:0] mk(input logic [2:0] alu, input logic [1:0] ext,
                                     input logic [1:0] npc, input logic [1:0] m5,
                                     input logic [1:0] m32, input logic m2,
                                     input logic pcwr, input logic irwr, input logic rw,
                                     input logic dm, input logic done, input logic ill);
    return {alu, ext, npc, m5, m32, m2, pcwr, irwr, rw, dm, done, ill};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        beqout;
    int          lat;
    logic [17:0] exp_exe;
    logic [17:0] exp_last;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  int n_chk  = 0;
  int n_pass = 0;

  // scoreboard: expected instret values, checked at the following IF
  logic [RET_W-1:0] exp_q[$];
  logic [RET_W-1:0] exp_ret = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // driver: called just after a rising edge with the DUT in S_IF
  task automatic run_instr(input int idx, input vec_t v);
    int   c;
    logic done;
    logic viol;
    // garbage on op/funct during IF must not matter
    op    = 6'($urandom_range(0, 63));
    funct = 6'($urandom_range(0, 63));
    @(negedge clk);
    chk($sformatf("v%0d if_state", idx), 32'(o_dbg_state), 32'd0);
    chk($sformatf("v%0d if_outs", idx), 32'(w_out), 32'(mk(0,0,0,0,0,0,0,1,0,0,0,0)));
    if (exp_q.size() > 0) chk($sformatf("v%0d instret", idx), 32'(instret), 32'(exp_q.pop_front()));
    @(posedge clk); #1;
    op = v.op; funct = v.funct; beqout = v.beqout;
    c = 2; done = 1'b0; viol = 1'b0;
    while (!done && c <= 8) begin
      @(negedge clk);
      if (c == 3) chk($sformatf("v%0d exe_outs", idx), 32'(w_out), 32'(v.exp_exe));
      if (PCWr) done = 1'b1;
      else begin
        if (RegWrt || DMWrite || IRWr) viol = 1'b1;
        @(posedge clk); #1;
        c++;
      end
    end
    chk($sformatf("v%0d latency", idx), 32'(c), 32'(v.lat));
    chk($sformatf("v%0d last_outs", idx), 32'(w_out), 32'(v.exp_last));
    chk($sformatf("v%0d early_write", idx), 32'(viol), 32'd0);
    exp_ret = exp_ret + 1'b1;
    exp_q.push_back(exp_ret);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t vj;
    //             op     funct  b  lat exp_exe                       exp_last
    vecs[0]  = '{6'h00, 6'h21, 0, 4, mk(0,0,0,0,0,0,0,0,0,0,0,0), mk(0,0,0,1,0,0,1,0,1,0,1,0)}; // addu
    vecs[1]  = '{6'h00, 6'h23, 0, 4, mk(1,0,0,0,0,0,0,0,0,0,0,0), mk(1,0,0,1,0,0,1,0,1,0,1,0)}; // subu
    vecs[2]  = '{6'h0D, 6'h15, 0, 4, mk(2,0,0,0,0,1,0,0,0,0,0,0), mk(2,0,0,0,0,1,1,0,1,0,1,0)}; // ori
    vecs[3]  = '{6'h0F, 6'h00, 0, 4, mk(0,2,0,0,0,0,0,0,0,0,0,0), mk(0,2,0,0,3,0,1,0,1,0,1,0)}; // lui
    vecs[4]  = '{6'h23, 6'h21, 0, 5, mk(0,1,0,0,0,1,0,0,0,0,0,0), mk(0,1,0,0,1,1,1,0,1,0,1,0)}; // lw
    vecs[5]  = '{6'h2B, 6'h00, 0, 4, mk(0,1,0,0,0,1,0,0,0,0,0,0), mk(0,1,0,0,0,1,1,0,0,1,1,0)}; // sw
    vecs[6]  = '{6'h04, 6'h00, 1, 3, mk(1,1,1,0,0,0,1,0,0,0,1,0), mk(1,1,1,0,0,0,1,0,0,0,1,0)}; // beq taken
    vecs[7]  = '{6'h04, 6'h00, 0, 3, mk(1,1,0,0,0,0,1,0,0,0,1,0), mk(1,1,0,0,0,0,1,0,0,0,1,0)}; // beq not taken
    vecs[8]  = '{6'h02, 6'h00, 0, 2, mk(0,0,0,0,0,0,0,0,0,0,0,0), mk(0,0,2,0,0,0,1,0,0,0,1,0)}; // j
    vecs[9]  = '{6'h03, 6'h00, 0, 2, mk(0,0,0,0,0,0,0,0,0,0,0,0), mk(0,0,2,2,2,0,1,0,1,0,1,0)}; // jal
    vecs[10] = '{6'h3F, 6'h00, 0, 2, mk(0,0,0,0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,1,0,0,0,1,1)}; // illegal op
    vecs[11] = '{6'h00, 6'h20, 0, 2, mk(0,0,0,0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,1,0,0,0,1,1)}; // illegal funct
    vj = vecs[8];

    // power-on reset
    #1 rst = 1'b0;
    #3;
    chk("por_state", 32'(o_dbg_state), 32'd0);
    chk("por_outs", 32'(w_out), 32'(mk(0,0,0,0,0,0,0,1,0,0,0,0)));
    chk("por_instret", 32'(instret), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.push_back('0);

    for (int i = 0; i < NV; i++) run_instr(i, vecs[i]);

    // reset in the middle of lw (S_MEM)
    op = 6'h11;
    @(negedge clk);
    chk("pre_rst instret", 32'(instret), 32'(exp_q.pop_front()));
    @(posedge clk); #1;
    op = 6'h23; funct = 6'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("lw_in_mem", 32'(o_dbg_state), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("rst_state", 32'(o_dbg_state), 32'd0);
    chk("rst_regwrt", 32'(RegWrt), 32'd0);
    chk("rst_dmwrite", 32'(DMWrite), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);
    chk("rst_outs", 32'(w_out), 32'(mk(0,0,0,0,0,0,0,1,0,0,0,0)));
    @(posedge clk); #1;
    chk("rst_held", 32'(o_dbg_state), 32'd0);
    rst = 1'b1;
    exp_ret = '0;
    exp_q.delete();
    exp_q.push_back('0);

    // instret wrap: 16 retirements take a 4-bit counter 15 -> 0
    for (int i = 0; i < 16; i++) run_instr(100 + i, vj);
    @(negedge clk);
    chk("wrap instret", 32'(instret), 32'(exp_q.pop_front()));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // absolute watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
